rvfi_retire_tracker: RTL and testbench

Parametrised retirement monitor for the mp4 testbench. It generalises the single-lane commit/order/halt logic to NUM_CH retire lanes per cycle, as needed for superscalar/OoO cores. Per lane it assigns RVFI order numbers and counts retired instructions. It detects halt (a self-loop repeated HALT_REPEAT times), a retirement watchdog timeout, and non-contiguous lane use. It sits between the core's retire stage and the RVFI/shadow-memory monitors.

---
 rtl/rvfi_tracker_pkg.sv | 17 +
 rtl/retire_prefix_count.sv | 31 +++
 rtl/rvfi_retire_tracker.sv | 178 +++++++++++++++++
 tb/tb_rvfi_retire_tracker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_tracker_pkg.sv
// Shared types and helpers for the multi-lane RVFI retirement tracker.
package rvfi_tracker_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam int unsigned MAX_CH = 8;

  // A lane mask is contiguous when its set bits form a run starting at lane 0.
  function automatic logic lanes_contiguous(input logic [MAX_CH-1:0] mask);
    return (mask & (mask + MAX_CH'(1))) == '0;
  endfunction

endpackage

// File: rtl/retire_prefix_count.sv
// Per-lane prefix popcount of accepted lanes, with every lane after the first
// halting lane cut from the accepted mask.
module retire_prefix_count #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic [NUM_CH-1:0]       valid_i,
  input  logic [NUM_CH-1:0]       hit_i,
  output logic [NUM_CH-1:0]       keep_c,
  output logic [NUM_CH*CNT_W-1:0] prefix_c,
  output logic [CNT_W-1:0]        total_c
);

  logic             cut;
  logic [CNT_W-1:0] run;

  always_comb begin
    cut      = 1'b0;
    run      = '0;
    keep_c   = '0;
    prefix_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      keep_c[i]                   = valid_i[i] & ~cut;
      prefix_c[i*CNT_W +: CNT_W]  = run;
      run                         = run + CNT_W'(keep_c[i]);
      if (keep_c[i] && hit_i[i]) cut = 1'b1;
    end
    total_c = run;
  end

endmodule

// File: rtl/rvfi_retire_tracker.sv
// Multi-lane retirement monitor: assigns RVFI order numbers, counts retirements,
// and flags halt (repeated self-loop), watchdog timeout and non-contiguous lanes.
module rvfi_retire_tracker
  import rvfi_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ORDER_W        = 64,
  parameter int unsigned HALT_REPEAT    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         commit_valid_i,
  input  logic [NUM_CH*XLEN-1:0]    commit_pc_rdata_i,
  input  logic [NUM_CH*XLEN-1:0]    commit_pc_wdata_i,
  output logic [NUM_CH-1:0]         out_valid_o,
  output logic [NUM_CH*ORDER_W-1:0] out_order_o,
  output logic [ORDER_W-1:0]        commit_count_o,
  output logic                      halt_o,
  output logic [XLEN-1:0]           halt_pc_o,
  output logic                      timeout_o,
  output logic                      lane_err_o
);

  localparam int unsigned CNT_W  = $clog2(NUM_CH + 1);
  localparam int unsigned LOOP_W = $clog2(HALT_REPEAT + 1);
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                    state_q, state_d;
  logic [ORDER_W-1:0]        count_q, count_d;
  logic [LOOP_W-1:0]         loop_cnt_q, loop_cnt_d;
  logic [XLEN-1:0]           loop_pc_q, loop_pc_d;
  logic [IDLE_W-1:0]         idle_q, idle_d;
  logic [NUM_CH-1:0]         out_valid_q, out_valid_d;
  logic [NUM_CH*ORDER_W-1:0] out_order_q, out_order_d;
  logic                      halt_q, halt_d;
  logic [XLEN-1:0]           halt_pc_q, halt_pc_d;
  logic                      timeout_q, timeout_d;
  logic                      lane_err_q, lane_err_d;

  logic [NUM_CH-1:0]         hit_c;
  logic [NUM_CH-1:0]         keep_c;
  logic [NUM_CH*CNT_W-1:0]   prefix_c;
  logic [CNT_W-1:0]          total_c;
  logic [LOOP_W-1:0]         scan_cnt_c;
  logic [XLEN-1:0]           scan_pc_c;

  // Lane-ordered self-loop scan; the first lane reaching HALT_REPEAT is the cut point.
  always_comb begin
    logic [LOOP_W-1:0] cnt;
    logic [XLEN-1:0]   lpc;
    logic [XLEN-1:0]   rd;
    logic [XLEN-1:0]   wd;
    logic              done;
    cnt   = loop_cnt_q;
    lpc   = loop_pc_q;
    done  = 1'b0;
    rd    = '0;
    wd    = '0;
    hit_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd = commit_pc_rdata_i[i*XLEN +: XLEN];
      wd = commit_pc_wdata_i[i*XLEN +: XLEN];
      if (commit_valid_i[i] && !done) begin
        if (wd == rd) begin
          if (lpc == rd) begin
            if (cnt < LOOP_W'(HALT_REPEAT)) cnt = cnt + LOOP_W'(1);
          end else begin
            cnt = LOOP_W'(1);
            lpc = rd;
          end
        end else begin
          cnt = '0;
        end
        if (cnt == LOOP_W'(HALT_REPEAT)) begin
          hit_c[i] = 1'b1;
          done     = 1'b1;
        end
      end
    end
    scan_cnt_c = cnt;
    scan_pc_c  = lpc;
  end

  retire_prefix_count #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_prefix (
    .valid_i  (commit_valid_i),
    .hit_i    (hit_c),
    .keep_c   (keep_c),
    .prefix_c (prefix_c),
    .total_c  (total_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    loop_cnt_d  = loop_cnt_q;
    loop_pc_d   = loop_pc_q;
    idle_d      = idle_q;
    out_valid_d = '0;
    out_order_d = '0;
    halt_d      = halt_q;
    halt_pc_d   = halt_pc_q;
    timeout_d   = timeout_q;
    lane_err_d  = lane_err_q;
    unique case (state_q)
      ST_RUN: begin
        if (!lanes_contiguous(MAX_CH'(commit_valid_i))) lane_err_d = 1'b1;
        out_valid_d = keep_c;
        for (int i = 0; i < NUM_CH; i++) begin
          if (keep_c[i]) begin
            out_order_d[i*ORDER_W +: ORDER_W] = count_q + ORDER_W'(prefix_c[i*CNT_W +: CNT_W]);
          end
        end
        count_d    = count_q + ORDER_W'(total_c);
        loop_cnt_d = scan_cnt_c;
        loop_pc_d  = scan_pc_c;
        if (|hit_c) begin
          state_d   = ST_HALTED;
          halt_d    = 1'b1;
          halt_pc_d = scan_pc_c;
          idle_d    = '0;
        end else if (|commit_valid_i) begin
          idle_d = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          idle_d = idle_q + IDLE_W'(1);
          if (idle_d == IDLE_W'(TIMEOUT_CYCLES)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      loop_cnt_q  <= '0;
      loop_pc_q   <= '0;
      idle_q      <= '0;
      out_valid_q <= '0;
      out_order_q <= '0;
      halt_q      <= 1'b0;
      halt_pc_q   <= '0;
      timeout_q   <= 1'b0;
      lane_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      loop_cnt_q  <= loop_cnt_d;
      loop_pc_q   <= loop_pc_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_order_q <= out_order_d;
      halt_q      <= halt_d;
      halt_pc_q   <= halt_pc_d;
      timeout_q   <= timeout_d;
      lane_err_q  <= lane_err_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_order_o    = out_order_q;
  assign commit_count_o = count_q;
  assign halt_o         = halt_q;
  assign halt_pc_o      = halt_pc_q;
  assign timeout_o      = timeout_q;
  assign lane_err_o     = lane_err_q;

endmodule

// File: tb/tb_rvfi_retire_tracker.sv
// Bench for rvfi_retire_tracker: directed vector table plus randomized traffic
// checked against a retirement-level reference model.
module tb_rvfi_retire_tracker;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ORD_W  = 64;
  localparam int unsigned HR     = 2;
  localparam int unsigned TO     = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       commit_valid_i = '0;
  logic [NUM_CH*XLEN-1:0]  commit_pc_rdata_i = '0;
  logic [NUM_CH*XLEN-1:0]  commit_pc_wdata_i = '0;
  logic [NUM_CH-1:0]       out_valid_o;
  logic [NUM_CH*ORD_W-1:0] out_order_o;
  logic [ORD_W-1:0]        commit_count_o;
  logic                    halt_o;
  logic [XLEN-1:0]         halt_pc_o;
  logic                    timeout_o;
  logic                    lane_err_o;

  rvfi_retire_tracker #(
    .NUM_CH(NUM_CH), .XLEN(XLEN), .ORDER_W(ORD_W),
    .HALT_REPEAT(HR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid_i),
    .commit_pc_rdata_i(commit_pc_rdata_i),
    .commit_pc_wdata_i(commit_pc_wdata_i),
    .out_valid_o(out_valid_o), .out_order_o(out_order_o),
    .commit_count_o(commit_count_o),
    .halt_o(halt_o), .halt_pc_o(halt_pc_o),
    .timeout_o(timeout_o), .lane_err_o(lane_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [31:0] rd0, wd0, rd1, wd1;
    logic [1:0]  ov;
    logic [63:0] o0, o1, cnt;
    logic        halt;
    logic [31:0] hpc;
    logic        to;
    logic        err;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, tracked per retirement.
  logic [63:0] m_base;
  int          m_loop;
  logic [31:0] m_lpc;
  int          m_idle;
  logic        m_halt, m_to, m_err;
  logic [31:0] m_hpc;

  function automatic vec_t mk(logic r, logic [1:0] v, logic [31:0] rd0, logic [31:0] wd0,
                              logic [31:0] rd1, logic [31:0] wd1, logic [1:0] ov,
                              logic [63:0] o0, logic [63:0] o1, logic [63:0] cnt,
                              logic halt, logic [31:0] hpc, logic to, logic err);
    vec_t t;
    t.rst = r; t.v = v; t.rd0 = rd0; t.wd0 = wd0; t.rd1 = rd1; t.wd1 = wd1;
    t.ov = ov; t.o0 = o0; t.o1 = o1; t.cnt = cnt;
    t.halt = halt; t.hpc = hpc; t.to = to; t.err = err;
    return t;
  endfunction

  task automatic chk(string nm, int step, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, step, act, exp);
  endtask

  task automatic drive(vec_t s);
    rst               = s.rst;
    commit_valid_i    = s.v;
    commit_pc_rdata_i = {s.rd1, s.rd0};
    commit_pc_wdata_i = {s.wd1, s.wd0};
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(vec_t e, int step);
    chk("out_valid", step, 64'(out_valid_o), 64'(e.ov));
    if (e.ov[0]) chk("order_lane0", step, out_order_o[63:0], e.o0);
    if (e.ov[1]) chk("order_lane1", step, out_order_o[127:64], e.o1);
    chk("commit_count", step, commit_count_o, e.cnt);
    chk("halt", step, 64'(halt_o), 64'(e.halt));
    chk("halt_pc", step, 64'(halt_pc_o), 64'(e.hpc));
    chk("timeout", step, 64'(timeout_o), 64'(e.to));
    chk("lane_err", step, 64'(lane_err_o), 64'(e.err));
  endtask

  // Expected registered outputs after one cycle with stimulus s.
  task automatic model(input vec_t s, output vec_t e);
    logic [31:0] rd [2];
    logic [31:0] wd [2];
    int          k;
    bit          stop;
    bit          gap;
    e = s;
    e.ov = 2'b00; e.o0 = '0; e.o1 = '0;
    rd[0] = s.rd0; rd[1] = s.rd1; wd[0] = s.wd0; wd[1] = s.wd1;
    if (s.rst) begin
      m_base = '0; m_loop = 0; m_lpc = '0; m_idle = 0;
      m_halt = 0; m_to = 0; m_err = 0; m_hpc = '0;
    end else if (!m_halt && !m_to) begin
      gap = 0;
      for (int l = 0; l < 2; l++) begin
        if (!s.v[l]) gap = 1;
        else if (gap) m_err = 1;
      end
      k = 0; stop = 0;
      for (int l = 0; l < 2; l++) begin
        if (s.v[l] && !stop) begin
          e.ov[l] = 1'b1;
          if (l == 0) e.o0 = m_base + 64'(k);
          else        e.o1 = m_base + 64'(k);
          k++;
          if (wd[l] == rd[l]) begin
            if (m_lpc == rd[l]) m_loop = (m_loop + 1 > HR) ? HR : m_loop + 1;
            else begin m_loop = 1; m_lpc = rd[l]; end
          end else begin
            m_loop = 0;
          end
          if (m_loop == HR) begin stop = 1; m_halt = 1; m_hpc = m_lpc; end
        end
      end
      m_base = m_base + 64'(k);
      if (s.v != 2'b00) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) m_to = 1;
      end
    end
    e.cnt = m_base; e.halt = m_halt; e.hpc = m_hpc; e.to = m_to; e.err = m_err;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t s, e;
    // Directed table: {rst, valid, rd0, wd0, rd1, wd1 | ov, o0, o1, count, halt, halt_pc, timeout, lane_err}
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0,                   2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 'h60, 'h64, 'h64, 'h68,       2'b11, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 'h60, 'h64, 'h64, 'h68,       2'b11, 2, 3, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 'h60, 'h64, 'h64, 'h68,       2'b11, 4, 5, 6, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 'h70, 'h74,             2'b10, 0, 6, 7, 0, 0, 0, 1));
    tbl.push_back(mk(0, 2'b11, 'h80, 'h80, 'h80, 'h80,       2'b11, 7, 8, 9, 1, 'h80, 0, 1));
    tbl.push_back(mk(0, 2'b11, 'h60, 'h64, 'h64, 'h68,       2'b00, 0, 0, 9, 1, 'h80, 0, 1));
    tbl.push_back(mk(1, 2'b11, 'h60, 'h64, 'h64, 'h68,       2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 'h100, 'h104, 0, 0,           2'b01, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 'h7c, 'h80, 'h80, 'h80,       2'b11, 1, 2, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 'h80, 'h80, 'h84, 'h88,       2'b01, 3, 0, 4, 1, 'h80, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0,                   2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 'h200, 'h204, 0, 0,           2'b01, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0,                 2'b00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0,                   2'b00, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b11, 'h60, 'h64, 'h64, 'h68,       2'b00, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0,                   2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 'h200, 'h204, 0, 0,           2'b01, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0,                 2'b00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 'h204, 'h208, 0, 0,           2'b01, 1, 0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0,                 2'b00, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0,                   2'b00, 0, 0, 2, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check_vec(tbl[i], i);
    end

    // Randomized traffic against the reference model.
    s = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pcs [3];
      pcs[0] = 32'h80; pcs[1] = 32'h84; pcs[2] = 32'h100;
      if (c == 0) s.rst = 1'b1;
      else if ((m_halt || m_to) && $urandom_range(0, 3) == 0) s.rst = 1'b1;
      else s.rst = ($urandom_range(0, 299) == 0);
      s.v   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      s.rd0 = pcs[$urandom_range(0, 2)];
      s.rd1 = pcs[$urandom_range(0, 2)];
      s.wd0 = ($urandom_range(0, 2) == 0) ? s.rd0 : s.rd0 + 32'd4;
      s.wd1 = ($urandom_range(0, 2) == 0) ? s.rd1 : s.rd1 + 32'd4;
      model(s, e);
      drive(s);
      check_vec(e, 1000 + c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
